// File: rtl/vga_pkg.sv
// 640x480@60 raster timing constants and shared widths for the VGA scan generator.
package vga_pkg;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int CNT_W  = 10;  // raster counters and pixel coordinates
    localparam int FCNT_W = 8;   // frame divider counter
endpackage

// File: rtl/mod_counter.sv
// Modulo-MAX counter with enable; wrap_o pulses in the enabled cycle that returns to 0.
module mod_counter #(
    parameter int MAX = 800,
    parameter int W   = 10
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = en_i && (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster/sync generator with a per-frame latched box overlay and a frame-divided
// animation level. Every output is registered one cycle behind the counters.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int BOX_SIZE  = 16,
    parameter int FRAME_DIV = 30
) (
    input  logic             pixel_clock,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] box_x,
    input  logic [CNT_W-1:0] box_y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             show,
    output logic             frame_start,
    output logic             fsm_clock
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0]  HV     = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0]  HS_BEG = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0]  HS_END = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0]  VV     = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0]  VS_BEG = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0]  VS_END = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [CNT_W:0]    BOX_W  = (CNT_W + 1)'(BOX_SIZE);
    localparam logic [FCNT_W-1:0] FDIV_LAST = FCNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, v_wrap_unused;

    mod_counter #(.MAX(H_TOTAL), .W(CNT_W)) u_hcnt (
        .clk_i   (pixel_clock),
        .rst_n_i (reset_n),
        .en_i    (1'b1),
        .cnt_o   (h_cnt),
        .wrap_o  (h_wrap)
    );

    mod_counter #(.MAX(V_TOTAL), .W(CNT_W)) u_vcnt (
        .clk_i   (pixel_clock),
        .rst_n_i (reset_n),
        .en_i    (h_wrap),
        .cnt_o   (v_cnt),
        .wrap_o  (v_wrap_unused)
    );

    logic [CNT_W-1:0]  bx_q, by_q, bx_d, by_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              fsm_q, fsm_d;
    logic              hsync_q, vsync_q, vid_q, show_q, fs_q;
    logic [CNT_W-1:0]  px_q, py_q;
    logic              at_origin, vis, in_box;

    // At (0,0) the box input is used directly so the first pixel already sees the new frame's box.
    always_comb begin
        at_origin = (h_cnt == '0) && (v_cnt == '0);
        vis       = (h_cnt < HV) && (v_cnt < VV);
        bx_d      = at_origin ? box_x : bx_q;
        by_d      = at_origin ? box_y : by_q;
        // 11-bit compare: bx+BOX_SIZE cannot wrap, and vis clips at the visible edge
        in_box    = ({1'b0, h_cnt} >= {1'b0, bx_d}) && ({1'b0, h_cnt} < {1'b0, bx_d} + BOX_W) &&
                    ({1'b0, v_cnt} >= {1'b0, by_d}) && ({1'b0, v_cnt} < {1'b0, by_d} + BOX_W);
        fcnt_d    = fcnt_q;
        fsm_d     = fsm_q;
        if (at_origin) begin
            if (fcnt_q == FDIV_LAST) begin
                fcnt_d = '0;
                fsm_d  = ~fsm_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            vid_q   <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            show_q  <= 1'b0;
            fs_q    <= 1'b0;
            fsm_q   <= 1'b0;
            fcnt_q  <= '0;
            bx_q    <= '0;
            by_q    <= '0;
        end else begin
            hsync_q <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
            vsync_q <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
            vid_q   <= vis;
            px_q    <= vis ? h_cnt : '0;
            py_q    <= vis ? v_cnt : '0;
            show_q  <= vis && in_box;
            fs_q    <= at_origin;
            fsm_q   <= fsm_d;
            fcnt_q  <= fcnt_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = vid_q;
    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign show        = show_q;
    assign frame_start = fs_q;
    assign fsm_clock   = fsm_q;
endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen on a shrunken raster: per-cycle arithmetic reference plus literal frame counts.
module tb_vga_scan_gen;
    localparam int HV = 40, HF = 4, HS = 6, HB = 6, HT = HV + HF + HS + HB;  // 56
    localparam int VV = 30, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;  // 37
    localparam int FRAME = HT * VT;                                          // 2072
    localparam int BOX = 16, FDIV = 2;

    logic       pixel_clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] box_x = 10'd10, box_y = 10'd5;
    logic       hsync, vsync, video_on, show, frame_start, fsm_clock;
    logic [9:0] pixel_x, pixel_y;

    int n_cmp = 0, n_bad = 0;
    int m_n = 0, m_bx = 0, m_by = 0;
    bit chk_en = 1'b0;

    // per-frame tallies filled by run_frame
    int c_show, c_vid, c_hs, c_vs, c_fs, c_stray, c_x5, c_x21, c_hs_first, c_vs_first;
    logic [22:0] s0;
    logic        fsm0;

    always #5 pixel_clock = ~pixel_clock;

    vga_scan_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .BOX_SIZE(BOX), .FRAME_DIV(FDIV)
    ) dut (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .box_x       (box_x),
        .box_y       (box_y),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .show        (show),
        .frame_start (frame_start),
        .fsm_clock   (fsm_clock)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 25) $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference time base: m_n is the output cycle index since reset (0 = reset values showing).
    // Output cycle n>=1 presents raster position p=n-1; the box for a frame is the input seen
    // at the edge that presents that frame's first pixel.
    always @(posedge pixel_clock) begin
        if (!reset_n) begin
            m_n = 0;
        end else begin
            m_n++;
            if ((m_n - 1) % FRAME == 0) begin
                m_bx = int'(box_x);
                m_by = int'(box_y);
            end
        end
    end

    always @(negedge pixel_clock) begin : compare
        int p, h, v, k;
        logic e_vis, e_hs, e_vs, e_fs, e_fsm, e_sh;
        logic [9:0] e_px, e_py;
        if (chk_en) begin
            if (m_n == 0) begin
                {e_hs, e_vs, e_vis, e_fs, e_fsm, e_sh} = 6'b110000;
                e_px = '0;
                e_py = '0;
            end else begin
                p     = m_n - 1;
                h     = p % HT;
                v     = (p / HT) % VT;
                k     = p / FRAME + 1;
                e_vis = (h < HV) && (v < VV);
                e_hs  = !(h >= HV + HF && h < HV + HF + HS);
                e_vs  = !(v >= VV + VF && v < VV + VF + VS);
                e_fs  = (p % FRAME) == 0;
                e_fsm = ((k / FDIV) % 2) == 1;
                e_sh  = e_vis && h >= m_bx && h < m_bx + BOX && v >= m_by && v < m_by + BOX;
                e_px  = e_vis ? 10'(h) : 10'd0;
                e_py  = e_vis ? 10'(v) : 10'd0;
            end
            chk("raster", {6'd0, hsync, vsync, video_on, frame_start, fsm_clock, show, pixel_x, pixel_y},
                          {6'd0, e_hs, e_vs, e_vis, e_fs, e_fsm, e_sh, e_px, e_py});
        end
    end

    // One full frame of output cycles; at iteration chg_at the box inputs switch to (nbx,nby).
    task automatic run_frame(input int chg_at, input logic [9:0] nbx, input logic [9:0] nby);
        c_show = 0; c_vid = 0; c_hs = 0; c_vs = 0; c_fs = 0; c_stray = 0; c_x5 = 0; c_x21 = 0;
        c_hs_first = -1; c_vs_first = -1;
        for (int i = 0; i < FRAME; i++) begin
            if (i == chg_at) begin
                box_x = nbx;
                box_y = nby;
            end
            @(negedge pixel_clock);
            if (i == 0) begin
                s0   = {frame_start, video_on, show, pixel_x, pixel_y};
                fsm0 = fsm_clock;
            end
            if (show)        c_show++;
            if (video_on)    c_vid++;
            if (!hsync)      c_hs++;
            if (!vsync)      c_vs++;
            if (frame_start) c_fs++;
            if (show && (pixel_x < 16 || pixel_y < 16)) c_stray++;
            if (show && pixel_x == 10'd5)  c_x5++;
            if (show && pixel_x == 10'd21) c_x21++;
            if (!hsync && c_hs_first < 0) c_hs_first = i;
            if (!vsync && c_vs_first < 0) c_vs_first = i;
        end
    endtask

    function automatic logic [9:0] rnd_coord();
        return ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 45));
    endfunction

    initial begin
        bit found;
        logic exp_fsm [6];
        exp_fsm = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge pixel_clock);
        chk_en = 1'b1;
        chk("reset_outputs", {hsync, vsync, video_on, show, frame_start, fsm_clock, pixel_x, pixel_y},
                             {6'b110000, 20'd0});
        reset_n = 1'b1;

        // frame 0: box (10,5), fully visible
        run_frame(-1, 10'd0, 10'd0);
        chk("f0_first_pixel", 32'(s0), {9'd0, 3'b110, 20'd0});
        chk("f0_show_cnt",    c_show, 256);
        chk("f0_video_cnt",   c_vid, HV * VV);
        chk("f0_hsync_low",   c_hs, HS * VT);
        chk("f0_vsync_low",   c_vs, VS * HT);
        chk("f0_frame_start", c_fs, 1);
        chk("f0_hsync_first", c_hs_first, 44);
        chk("f0_vsync_first", c_vs_first, 32 * HT);

        // frame 1: box clipped at the bottom-right corner
        run_frame(0, 10'd30, 10'd20);
        chk("f1_clip_show",   c_show, 100);
        chk("f1_no_wrap",     c_stray, 0);

        // frame 2: box (5,3), moved to x=20 at line 10 -> takes effect next frame
        box_x = 10'd5;
        box_y = 10'd3;
        run_frame(10 * HT + 7, 10'd20, 10'd3);
        chk("f2_old_col",     c_x5, 16);
        chk("f2_new_col",     c_x21, 0);
        run_frame(-1, 10'd0, 10'd0);
        chk("f3_old_col",     c_x5, 0);
        chk("f3_new_col",     c_x21, 16);
        chk("f3_show_cnt",    c_show, 256);

        // random boxes, changed at random points in the frame
        repeat (2) begin
            run_frame($urandom_range(0, FRAME - 1), rnd_coord(), rnd_coord());
            chk("rand_frame_start", c_fs, 1);
        end

        // into frame 6 (7th frame_start -> fsm_clock high); reset mid-line during vsync
        found = 1'b0;
        for (int i = 0; i < FRAME + 2 && !found; i++) begin
            @(negedge pixel_clock);
            if (vsync === 1'b0) found = 1'b1;
        end
        chk("vsync_seen", 32'(found), 32'd1);
        repeat ($urandom_range(5, 40)) @(negedge pixel_clock);
        chk("fsm_pre_reset", 32'(fsm_clock), 32'd1);
        reset_n = 1'b0;
        @(negedge pixel_clock);
        chk("mid_reset", {hsync, vsync, video_on, show, frame_start, fsm_clock, pixel_x, pixel_y},
                         {6'b110000, 20'd0});
        @(negedge pixel_clock);
        reset_n = 1'b1;

        for (int f = 0; f < 6; f++) begin
            run_frame(0, rnd_coord(), rnd_coord());
            if (f == 0) chk("restart_first_pixel", 32'({s0[22:21], s0[19:0]}), {10'd0, 2'b11, 20'd0});
            chk("fsm_at_frame_start", 32'(fsm0), 32'(exp_fsm[f]));
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
